execute_stage: RTL

- Execute (EXE) pipeline stage; sits between the decode/ID stage and mem_access, whose inputs it drives directly.
- Performs RV32I ALU ops in a single cycle and RV32M mul/div ops iteratively through a muldiv_unit sub-module.
- Registers its results plus pass-through control into the EXE/MEM pipeline registers.
- Asserts o_busy so the hazard unit holds ID/IF while a multi-cycle op is in flight.

---
 rtl/multicore_pkg.sv | 53 +++++
 rtl/muldiv_unit.sv | 126 ++++++++++++
 rtl/execute_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/multicore_pkg.sv
// Shared types and sizing for the multicore pipeline.
// Holds data/instruction widths, register-file sizing, load/store
// operation encodings and the EXE-stage ALU operation enum.
package multicore_pkg;

    localparam int unsigned DATA_SIZE  = 32;
    localparam int unsigned INST_SIZE  = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        LDOP_LW  = 3'd0,
        LDOP_LH  = 3'd1,
        LDOP_LB  = 3'd2,
        LDOP_LHU = 3'd3,
        LDOP_LBU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        SOP_SW = 2'd0,
        SOP_SH = 2'd1,
        SOP_SB = 2'd2
    } t_sop;

    typedef enum logic [4:0] {
        ALU_NOP    = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_SLL    = 5'd3,
        ALU_SLT    = 5'd4,
        ALU_SLTU   = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_OR     = 5'd9,
        ALU_AND    = 5'd10,
        ALU_LUI    = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19
    } t_aluop;

    function automatic logic is_muldiv(input t_aluop op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are captured as magnitudes plus sign flags, then one
// shift-add (mul) or restoring-subtract (div) step runs per cycle for
// MULDIV_CYCLES cycles; the sign fix-up is applied on the way out.
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset (wired to the core's i_areset_n)
//   i_start  an M op is presented; accepted only when idle
//   i_op     operation select
//   i_a/i_b  operands (rs1/rs2)
//   i_kill   abort whatever is in progress, return to idle
//   i_ack    result consumed while done
//   o_busy   operation pending (combinational)
//   o_done   result valid
//   o_result sign-fixed result
module muldiv_unit
    import multicore_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  t_aluop               i_op,
    input  logic [DATA_SIZE-1:0] i_a,
    input  logic [DATA_SIZE-1:0] i_b,
    input  logic                 i_kill,
    input  logic                 i_ack,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DATA_SIZE-1:0] o_result
);

    localparam int unsigned CW = $clog2(MULDIV_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} t_state;

    t_state               state;
    t_aluop               op_q;
    logic                 sa_q, sb_q;
    logic [DATA_SIZE-1:0] mb_q;
    logic [DATA_SIZE-1:0] acc_q;   // mul: product high half / div: remainder
    logic [DATA_SIZE-1:0] qr_q;    // mul: multiplier->product low / div: dividend->quotient
    logic [CW-1:0]        cnt_q;

    logic                 a_neg, b_neg, is_mul_q;
    logic [DATA_SIZE-1:0] a_mag, b_mag;
    logic [DATA_SIZE:0]   mul_sum, div_rs, div_diff;
    logic [2*DATA_SIZE-1:0] product, prod_fix;
    logic [DATA_SIZE-1:0] quot_fix, rem_fix;

    always_comb begin
        a_neg    = i_a[DATA_SIZE-1] && (i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
        b_neg    = i_b[DATA_SIZE-1] && (i_op inside {ALU_MULH, ALU_DIV, ALU_REM});
        a_mag    = a_neg ? ('0 - i_a) : i_a;
        b_mag    = b_neg ? ('0 - i_b) : i_b;
        is_mul_q = op_q inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
        mul_sum  = {1'b0, acc_q} + (qr_q[0] ? {1'b0, mb_q} : '0);
        div_rs   = {acc_q, qr_q[DATA_SIZE-1]};
        div_diff = div_rs - {1'b0, mb_q};
    end

    // Divide-by-zero falls out naturally (all-ones quotient, remainder =
    // |dividend|); only the quotient negation must be suppressed for it.
    always_comb begin
        product  = {acc_q, qr_q};
        prod_fix = (sa_q ^ sb_q) ? ('0 - product) : product;
        quot_fix = ((sa_q ^ sb_q) && (mb_q != '0)) ? ('0 - qr_q) : qr_q;
        rem_fix  = sa_q ? ('0 - acc_q) : acc_q;
        case (op_q)
            ALU_MUL:                         o_result = prod_fix[DATA_SIZE-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = prod_fix[2*DATA_SIZE-1:DATA_SIZE];
            ALU_DIV, ALU_DIVU:               o_result = quot_fix;
            ALU_REM, ALU_REMU:               o_result = rem_fix;
            default:                         o_result = '0;
        endcase
    end

    assign o_busy = !i_kill && (((state == S_IDLE) && i_start) || (state == S_CALC));
    assign o_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= ALU_NOP;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            mb_q  <= '0;
            acc_q <= '0;
            qr_q  <= '0;
            cnt_q <= '0;
        end else if (i_kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    op_q  <= i_op;
                    sa_q  <= a_neg;
                    sb_q  <= b_neg;
                    mb_q  <= b_mag;
                    acc_q <= '0;
                    qr_q  <= a_mag;
                    cnt_q <= '0;
                    state <= S_CALC;
                end
                S_CALC: begin
                    if (is_mul_q) begin
                        acc_q <= mul_sum[DATA_SIZE:1];
                        qr_q  <= {mul_sum[0], qr_q[DATA_SIZE-1:1]};
                    end else if (!div_diff[DATA_SIZE]) begin
                        acc_q <= div_diff[DATA_SIZE-1:0];
                        qr_q  <= {qr_q[DATA_SIZE-2:0], 1'b1};
                    end else begin
                        acc_q <= div_rs[DATA_SIZE-1:0];
                        qr_q  <= {qr_q[DATA_SIZE-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(MULDIV_CYCLES - 1)) state <= S_DONE;
                end
                S_DONE: if (i_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// EXE pipeline stage: single-cycle RV32I ALU plus iterative RV32M
// through muldiv_unit, feeding the EXE/MEM pipeline registers.
// Ports:
//   i_aclk/i_areset_n  clock, asynchronous active-low reset
//   i_en               advance enable; i_flush kills the EXE instruction
//   i_rs1_data/i_rs2_data/i_imm/i_alusrc/i_aluop  operands and op select
//   i_pcplus4, i_rdest, i_mem_we, i_cu_memaccess, i_cu_regwrite,
//   i_ldop, i_sop, i_cu_memtoreg                  control pass-through
//   o_exe_out          registered result / memory address
//   o_mem_wdata        registered store data (rs2)
//   o_*                registered copies of the pass-through inputs
//   o_busy             multi-cycle op pending (combinational)
module execute_stage
    import multicore_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32   // must equal DATA_SIZE
) (
    input  logic                  i_aclk,
    input  logic                  i_areset_n,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic [DATA_SIZE-1:0]  i_rs1_data,
    input  logic [DATA_SIZE-1:0]  i_rs2_data,
    input  logic [DATA_SIZE-1:0]  i_imm,
    input  logic                  i_alusrc,
    input  t_aluop                i_aluop,
    input  logic [INST_SIZE-1:0]  i_pcplus4,
    input  logic [REG_ADDR_W-1:0] i_rdest,
    input  logic                  i_mem_we,
    input  logic                  i_cu_memaccess,
    input  logic                  i_cu_regwrite,
    input  t_ldop                 i_ldop,
    input  t_sop                  i_sop,
    input  logic [1:0]            i_cu_memtoreg,
    output logic [DATA_SIZE-1:0]  o_exe_out,
    output logic [DATA_SIZE-1:0]  o_mem_wdata,
    output logic [INST_SIZE-1:0]  o_pcplus4,
    output logic [REG_ADDR_W-1:0] o_rdest,
    output logic                  o_mem_we,
    output logic                  o_cu_memaccess,
    output logic                  o_cu_regwrite,
    output t_ldop                 o_ldop,
    output t_sop                  o_sop,
    output logic [1:0]            o_cu_memtoreg,
    output logic                  o_busy
);

    localparam int unsigned SHW = $clog2(DATA_SIZE);

    logic [DATA_SIZE-1:0] alu_b, alu_res, md_result;
    logic [SHW-1:0]       shamt;
    logic                 md_busy, md_done;

    assign alu_b = i_alusrc ? i_imm : i_rs2_data;
    assign shamt = alu_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (i_aluop)
            ALU_ADD:  alu_res = i_rs1_data + alu_b;
            ALU_SUB:  alu_res = i_rs1_data - alu_b;
            ALU_SLL:  alu_res = i_rs1_data << shamt;
            ALU_SLT:  alu_res = {{(DATA_SIZE-1){1'b0}}, ($signed(i_rs1_data) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(DATA_SIZE-1){1'b0}}, (i_rs1_data < alu_b)};
            ALU_XOR:  alu_res = i_rs1_data ^ alu_b;
            ALU_SRL:  alu_res = i_rs1_data >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(i_rs1_data) >>> shamt);
            ALU_OR:   alu_res = i_rs1_data | alu_b;
            ALU_AND:  alu_res = i_rs1_data & alu_b;
            ALU_LUI:  alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    muldiv_unit #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_muldiv (
        .clk      (i_aclk),
        .rst      (i_areset_n),
        .i_start  (is_muldiv(i_aluop)),
        .i_op     (i_aluop),
        .i_a      (i_rs1_data),
        .i_b      (i_rs2_data),
        .i_kill   (i_flush),
        .i_ack    (i_en),
        .o_busy   (md_busy),
        .o_done   (md_done),
        .o_result (md_result)
    );

    assign o_busy = md_busy;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_exe_out      <= '0;
            o_mem_wdata    <= '0;
            o_pcplus4      <= '0;
            o_rdest        <= '0;
            o_mem_we       <= 1'b0;
            o_cu_memaccess <= 1'b0;
            o_cu_regwrite  <= 1'b0;
            o_ldop         <= LDOP_LW;
            o_sop          <= SOP_SW;
            o_cu_memtoreg  <= '0;
        end else if (i_flush || (i_en && md_busy)) begin
            // bubble: only the side-effect controls matter downstream
            o_mem_we       <= 1'b0;
            o_cu_memaccess <= 1'b0;
            o_cu_regwrite  <= 1'b0;
        end else if (i_en) begin
            o_exe_out      <= (md_done && is_muldiv(i_aluop)) ? md_result : alu_res;
            o_mem_wdata    <= i_rs2_data;
            o_pcplus4      <= i_pcplus4;
            o_rdest        <= i_rdest;
            o_mem_we       <= i_mem_we;
            o_cu_memaccess <= i_cu_memaccess;
            o_cu_regwrite  <= i_cu_regwrite;
            o_ldop         <= i_ldop;
            o_sop          <= i_sop;
            o_cu_memtoreg  <= i_cu_memtoreg;
        end
    end

endmodule
